// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: opcodes, states,
// stack-error bit positions and the instruction word layout.
package pc_sequencer_pkg;

    localparam int unsigned INSTR_WIDTH   = 28;
    localparam int unsigned OPCODE_WIDTH  = 4;
    localparam int unsigned OPERAND_WIDTH = 24;
    localparam int unsigned TARGET_WIDTH  = 8;

    localparam int unsigned ERR_WIDTH     = 2;
    localparam int unsigned ERR_OVERFLOW  = 0;
    localparam int unsigned ERR_UNDERFLOW = 1;

    // Control-flow opcodes; every other value is a datapath op that just advances
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_CALL = 4'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_RET  = 4'h4;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]  opcode;
        logic [OPERAND_WIDTH-1:0] operand;
    } instr_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Sequencer-side bundle: ROM instruction and datapath controls in,
// PC and status out.
interface pc_sequencer_if #(
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned STACK_DEPTH = 4
) ();
    import pc_sequencer_pkg::*;

    localparam int unsigned DEPTH_WIDTH = $clog2(STACK_DEPTH) + 1;

    logic [INSTR_WIDTH-1:0] instruction;
    logic                   branch_taken;
    logic                   stall;
    logic [PC_WIDTH-1:0]    pc;
    logic                   busy;
    logic                   halted;
    logic [ERR_WIDTH-1:0]   stack_error;
    logic [DEPTH_WIDTH-1:0] stack_depth;

    modport master (
        input  instruction, branch_taken, stall,
        output pc, busy, halted, stack_error, stack_depth
    );

    modport slave (
        output instruction, branch_taken, stall,
        input  pc, busy, halted, stack_error, stack_depth
    );

endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Return-address LIFO; the top entry is visible combinationally for RET.
module pc_sequencer_return_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data_c,
    output logic                         full_c,
    output logic                         empty_c,
    output logic [$clog2(DEPTH):0]       depth
);
    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [CNT_WIDTH-1:0] depth_q;

    assign full_c    = (depth_q == CNT_WIDTH'(DEPTH));
    assign empty_c   = (depth_q == '0);
    assign rd_data_c = mem[PTR_WIDTH'(depth_q - CNT_WIDTH'(1))];
    assign depth     = depth_q;

    // Storage needs no reset: only entries below depth_q are ever read
    always_ff @(posedge clk) begin
        if (push && !full_c) begin
            mem[PTR_WIDTH'(depth_q)] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else if (push && !full_c) begin
            depth_q <= depth_q + CNT_WIDTH'(1);
        end else if (pop && !empty_c) begin
            depth_q <= depth_q - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: decodes control-flow opcodes, counts NOP delays
// and keeps CALL return addresses in a hardware stack.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned DELAY_WIDTH = 24
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);
    localparam int unsigned DEPTH_WIDTH = $clog2(STACK_DEPTH) + 1;

    instr_t                 instr;
    logic [PC_WIDTH-1:0]    pc_q, pc_nxt, pc_inc, target, ret_addr;
    logic [DELAY_WIDTH-1:0] cnt_q, cnt_nxt;
    seq_state_e             state_q, state_nxt;
    logic [ERR_WIDTH-1:0]   err_q, err_nxt;
    logic                   busy_q, halted_q;
    logic                   push, pop, full, empty;
    logic [DEPTH_WIDTH-1:0] depth;

    assign instr  = instr_t'(bus.instruction);
    assign pc_inc = pc_q + PC_WIDTH'(1);
    assign target = PC_WIDTH'(instr.operand[OPERAND_WIDTH-1 -: TARGET_WIDTH]);

    pc_sequencer_return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wr_data   (pc_inc),
        .rd_data_c (ret_addr),
        .full_c    (full),
        .empty_c   (empty),
        .depth     (depth)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            pc_q     <= pc_nxt;
            cnt_q    <= cnt_nxt;
            err_q    <= err_nxt;
            busy_q   <= (state_nxt == ST_WAIT);
            halted_q <= (state_nxt == ST_HALT);
        end
    end

    // Next-state / next-PC; a stall leaves every default (hold) in place
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        cnt_nxt   = cnt_q;
        err_nxt   = err_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (!bus.stall) begin
            case (state_q)
                ST_RUN: begin
                    case (instr.opcode)
                        OP_NOP: begin
                            if (instr.operand == '0) begin
                                pc_nxt = pc_inc;
                            end else begin
                                cnt_nxt   = DELAY_WIDTH'(instr.operand);
                                state_nxt = ST_WAIT;
                            end
                        end
                        OP_JMP: pc_nxt = target;
                        OP_BLE: pc_nxt = bus.branch_taken ? target : pc_inc;
                        OP_CALL: begin
                            if (full) begin
                                err_nxt[ERR_OVERFLOW] = 1'b1;
                                state_nxt             = ST_HALT;
                            end else begin
                                push   = 1'b1;
                                pc_nxt = target;
                            end
                        end
                        OP_RET: begin
                            if (empty) begin
                                err_nxt[ERR_UNDERFLOW] = 1'b1;
                                state_nxt              = ST_HALT;
                            end else begin
                                pop    = 1'b1;
                                pc_nxt = ret_addr;
                            end
                        end
                        default: pc_nxt = pc_inc;
                    endcase
                end
                ST_WAIT: begin
                    cnt_nxt = cnt_q - DELAY_WIDTH'(1);
                    if (cnt_q == DELAY_WIDTH'(1)) begin
                        pc_nxt    = pc_inc;
                        state_nxt = ST_RUN;
                    end
                end
                ST_HALT: state_nxt = ST_HALT;
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.stack_error = err_q;
    assign bus.stack_depth = depth;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a cycle-level reference model.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int PCW   = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    pc_sequencer_if #(.PC_WIDTH(PCW), .STACK_DEPTH(DEPTH)) bus ();

    pc_sequencer #(
        .STACK_DEPTH (DEPTH),
        .PC_WIDTH    (PCW),
        .DELAY_WIDTH (24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integers, a queue as the stack, remaining wait cycles
    int m_pc;
    int m_wait;
    int m_stack[$];
    bit m_halt;
    bit [1:0] m_err;

    always @(posedge clk) begin
        logic [27:0] ins;
        logic [3:0]  op;
        int          tgt;
        int          dly;
        int          nxt;
        ins = bus.instruction;
        op  = ins[27:24];
        tgt = int'(ins[23:16]);
        dly = int'(ins[23:0]);
        nxt = (m_pc + 1) % 65536;
        if (rst) begin
            m_pc = 0; m_wait = 0; m_stack.delete(); m_halt = 0; m_err = 2'b00;
        end else if (!bus.stall && !m_halt) begin
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_pc = nxt;
            end else begin
                case (op)
                    OP_NOP:  if (dly == 0) m_pc = nxt; else m_wait = dly;
                    OP_JMP:  m_pc = tgt;
                    OP_BLE:  m_pc = bus.branch_taken ? tgt : nxt;
                    OP_CALL: begin
                        if (m_stack.size() == DEPTH) begin
                            m_err[0] = 1'b1; m_halt = 1'b1;
                        end else begin
                            m_stack.push_back(nxt); m_pc = tgt;
                        end
                    end
                    OP_RET: begin
                        if (m_stack.size() == 0) begin
                            m_err[1] = 1'b1; m_halt = 1'b1;
                        end else begin
                            m_pc = m_stack.pop_back();
                        end
                    end
                    default: m_pc = nxt;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_pc",     32'(bus.pc),          32'(m_pc));
            check("model_busy",   32'(bus.busy),        32'(m_wait > 0));
            check("model_halted", 32'(bus.halted),      32'(m_halt));
            check("model_err",    32'(bus.stack_error), 32'(m_err));
            check("model_depth",  32'(bus.stack_depth), 32'(m_stack.size()));
        end
    end

    function automatic logic [27:0] mk(input logic [3:0] op, input logic [23:0] operand);
        return {op, operand};
    endfunction

    task automatic step(input logic [27:0] ins, input logic bt = 1'b0,
                        input logic st = 1'b0, input logic r = 1'b0);
        bus.instruction  = ins;
        bus.branch_taken = bt;
        bus.stall        = st;
        rst              = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [27:0] jmp(input int t);
        return mk(OP_JMP, {8'(t), 16'h0});
    endfunction

    function automatic logic [27:0] call(input int t);
        return mk(OP_CALL, {8'(t), 16'h0});
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] alu;
        logic [27:0] ret;
        alu = mk(4'h8, 24'h000000);
        ret = mk(OP_RET, 24'h0F0000);

        // Reset state
        step(alu, 1'b0, 1'b0, 1'b1);
        cmp_en = 1'b1;
        check("rst_pc", 32'(bus.pc), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_err", 32'(bus.stack_error), 32'd0);
        check("rst_depth", 32'(bus.stack_depth), 32'd0);

        // Plain advances
        step(mk(4'h8, 24'h123456)); check("adv_pc1", 32'(bus.pc), 32'd1);
        step(mk(4'h9, 24'h000001)); check("adv_pc2", 32'(bus.pc), 32'd2);
        step(mk(4'hF, 24'hFFFFFF)); check("adv_pc3", 32'(bus.pc), 32'd3);
        check("adv_busy", 32'(bus.busy), 32'd0);

        // NOP delay 3 at PC 5: four cycles at PC 5, three of them busy
        step(jmp(5));
        step(mk(OP_NOP, 24'd3)); check("nop_w1_pc", 32'(bus.pc), 32'd5);
        check("nop_w1_busy", 32'(bus.busy), 32'd1);
        step(alu); check("nop_w2_pc", 32'(bus.pc), 32'd5);
        step(alu); check("nop_w3_busy", 32'(bus.busy), 32'd1);
        step(alu); check("nop_exit_pc", 32'(bus.pc), 32'd6);
        check("nop_exit_busy", 32'(bus.busy), 32'd0);

        // Reset during the second wait cycle
        step(jmp(5));
        step(mk(OP_NOP, 24'd3));
        step(alu); check("nop_rst_pre", 32'(bus.busy), 32'd1);
        step(alu, 1'b0, 1'b0, 1'b1);
        check("nop_rst_pc", 32'(bus.pc), 32'd0);
        check("nop_rst_busy", 32'(bus.busy), 32'd0);

        // BLE / JMP
        step(jmp(12));
        step(mk(OP_BLE, 24'h090000), 1'b1); check("ble_taken", 32'(bus.pc), 32'd9);
        step(jmp(12));
        step(mk(OP_BLE, 24'h090000), 1'b0); check("ble_not", 32'(bus.pc), 32'd13);
        step(jmp(16));
        step(jmp(4)); check("jmp_pc", 32'(bus.pc), 32'd4);

        // Nested calls
        step(jmp(10));
        step(call(17)); check("call1_pc", 32'(bus.pc), 32'd17);
        check("call1_depth", 32'(bus.stack_depth), 32'd1);
        step(jmp(20));
        step(call(30)); check("call2_pc", 32'(bus.pc), 32'd30);
        check("call2_depth", 32'(bus.stack_depth), 32'd2);
        step(ret); check("ret1_pc", 32'(bus.pc), 32'd21);
        check("ret1_depth", 32'(bus.stack_depth), 32'd1);
        step(ret); check("ret2_pc", 32'(bus.pc), 32'd11);
        check("ret2_depth", 32'(bus.stack_depth), 32'd0);

        // Overflow on the fifth CALL
        for (int k = 0; k < 4; k++) step(call(40));
        check("full_depth", 32'(bus.stack_depth), 32'd4);
        step(call(40));
        check("ovf_err", 32'(bus.stack_error), 32'd1);
        check("ovf_halted", 32'(bus.halted), 32'd1);
        check("ovf_depth", 32'(bus.stack_depth), 32'd4);
        step(jmp(3)); check("halt_pc_frozen", 32'(bus.pc), 32'd40);

        // Underflow after reset
        step(alu, 1'b0, 1'b0, 1'b1);
        check("halt_rst", 32'(bus.halted), 32'd0);
        step(ret);
        check("unf_err", 32'(bus.stack_error), 32'd2);
        check("unf_halted", 32'(bus.halted), 32'd1);
        check("unf_pc", 32'(bus.pc), 32'd0);

        // Stall mid-WAIT: counter must hold across the stall
        step(alu, 1'b0, 1'b0, 1'b1);
        step(jmp(5));
        step(mk(OP_NOP, 24'd3));
        step(alu);
        step(alu, 1'b0, 1'b1); step(alu, 1'b0, 1'b1);
        check("stall_w_pc", 32'(bus.pc), 32'd5);
        check("stall_w_busy", 32'(bus.busy), 32'd1);
        step(alu); check("stall_w_hold", 32'(bus.busy), 32'd1);
        step(alu); check("stall_w_exit", 32'(bus.pc), 32'd6);

        // Stall on CALL
        step(call(50), 1'b0, 1'b1); step(call(50), 1'b0, 1'b1);
        check("stall_c_pc", 32'(bus.pc), 32'd6);
        check("stall_c_depth", 32'(bus.stack_depth), 32'd0);
        step(call(50)); check("stall_c_done", 32'(bus.pc), 32'd50);
        check("stall_c_dep1", 32'(bus.stack_depth), 32'd1);

        // PC wrap from 0xFFFF
        step(jmp(255));
        for (int k = 0; k < 65280; k++) step(alu);
        check("wrap_pre", 32'(bus.pc), 32'h0000FFFF);
        step(alu); check("wrap_pc", 32'(bus.pc), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
